avalon_crypto_csr_bank: RTL and testbench

Parametrised Avalon-MM slave register bank that fronts a block-cipher core. It is the next generation of the fixed 16-word AES interface, generalised in key/message word counts. It adds per-byte masked writes for any enable combination, a START pulse with a BUSY/DONE handshake, write protection while busy, sticky status bits, an interrupt and registered reads. It sits between the Avalon fabric and the AES core; the core is instantiated outside this block.

---
 rtl/crypto_csr_pkg.sv | 41 ++++
 rtl/byte_lane_register.sv | 21 ++
 rtl/avalon_crypto_csr_bank.sv | 187 ++++++++++++++++++
 tb/tb_avalon_crypto_csr_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/crypto_csr_pkg.sv
// Shared types, bit positions and address-map helpers for the crypto CSR bank.
package crypto_csr_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } csr_state_e;

  // STATUS register bit positions
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT  = 2;

  // CTRL register bit positions
  localparam int unsigned CTRL_START_BIT = 0;

  // Only the DONE and ERR enable bits of IEN are implemented
  localparam logic [31:0] IEN_MASK = 32'h0000_0006;

  // Register map: KEY, IN, OUT, then the four control words
  function automatic int unsigned out_base(input int unsigned k, input int unsigned m);
    return k + m;
  endfunction

  function automatic int unsigned ctrl_base(input int unsigned k, input int unsigned m);
    return k + 2 * m;
  endfunction

  function automatic int unsigned status_base(input int unsigned k, input int unsigned m);
    return ctrl_base(k, m) + 1;
  endfunction

  function automatic int unsigned ien_base(input int unsigned k, input int unsigned m);
    return ctrl_base(k, m) + 2;
  endfunction

  function automatic int unsigned id_base(input int unsigned k, input int unsigned m);
    return ctrl_base(k, m) + 3;
  endfunction

endpackage

// File: rtl/byte_lane_register.sv
// 32-bit register with an independent load enable per byte lane.
module byte_lane_register (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // Load each enabled byte lane; synchronous clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_crypto_csr_bank.sv
// Avalon-MM register bank fronting a block-cipher core: key/message registers,
// START/BUSY/DONE handshake, write protection while busy, sticky status and IRQ.
module avalon_crypto_csr_bank
  import crypto_csr_pkg::*;
#(
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned MSG_WORDS = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [31:0] ID_VALUE  = 32'h0000_AE59
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   AVL_READ,
  input  logic                   AVL_WRITE,
  input  logic                   AVL_CS,
  input  logic [3:0]             AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]      AVL_ADDR,
  input  logic [31:0]            AVL_WRITEDATA,
  output logic [31:0]            AVL_READDATA,
  output logic [32*KEY_WORDS-1:0] CORE_KEY,
  output logic [32*MSG_WORDS-1:0] CORE_MSG_IN,
  output logic                   CORE_START,
  input  logic                   CORE_DONE,
  input  logic [32*MSG_WORDS-1:0] CORE_MSG_OUT,
  output logic                   IRQ,
  output logic [31:0]            EXPORT_DATA
);

  localparam int unsigned OUT_BASE    = out_base(KEY_WORDS, MSG_WORDS);
  localparam int unsigned CTRL_BASE   = ctrl_base(KEY_WORDS, MSG_WORDS);
  localparam int unsigned STATUS_BASE = status_base(KEY_WORDS, MSG_WORDS);
  localparam int unsigned IEN_BASE    = ien_base(KEY_WORDS, MSG_WORDS);
  localparam int unsigned ID_BASE     = id_base(KEY_WORDS, MSG_WORDS);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(CTRL_BASE);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(STATUS_BASE);
  localparam logic [ADDR_W-1:0] ADDR_IEN    = ADDR_W'(IEN_BASE);
  localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(ID_BASE);

  if (KEY_WORDS + 2 * MSG_WORDS + 4 > 2 ** ADDR_W) begin : g_map_check
    $error("avalon_crypto_csr_bank: register map does not fit in ADDR_W address bits");
  end

  logic wr_en;
  logic rd_en;
  assign wr_en = AVL_CS && AVL_WRITE;
  assign rd_en = AVL_CS && AVL_READ;

  csr_state_e state_q, state_d;
  logic       busy;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       start_q, start_d;
  logic [31:0] readdata_q;
  logic [31:0] rdata_mux;

  logic [KEY_WORDS-1:0] key_hit;
  logic [MSG_WORDS-1:0] in_hit;
  logic [31:0]          key_q [KEY_WORDS];
  logic [31:0]          in_q  [MSG_WORDS];
  logic [31:0]          out_q [MSG_WORDS];
  logic [31:0]          ien_q;

  logic start_req;
  logic status_w1c;
  logic done_evt;
  logic err_set;

  assign busy       = (state_q == StBusy);
  assign start_req  = wr_en && (AVL_ADDR == ADDR_CTRL) && AVL_BYTE_EN[0] &&
                      AVL_WRITEDATA[CTRL_START_BIT];
  assign status_w1c = wr_en && (AVL_ADDR == ADDR_STATUS) && AVL_BYTE_EN[0];
  // CORE_DONE only counts while an operation is outstanding
  assign done_evt   = busy && CORE_DONE;
  assign err_set    = busy && ((|key_hit) || (|in_hit) || start_req);

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
    assign key_hit[i] = wr_en && (AVL_ADDR == ADDR_W'(i));
    byte_lane_register u_key (
      .clk     (CLK),
      .rst     (RESET),
      .byte_en ((key_hit[i] && !busy) ? AVL_BYTE_EN : 4'b0000),
      .wdata   (AVL_WRITEDATA),
      .q       (key_q[i])
    );
    assign CORE_KEY[32*i +: 32] = key_q[i];
  end

  for (genvar i = 0; i < MSG_WORDS; i++) begin : g_in
    assign in_hit[i] = wr_en && (AVL_ADDR == ADDR_W'(KEY_WORDS + i));
    byte_lane_register u_in (
      .clk     (CLK),
      .rst     (RESET),
      .byte_en ((in_hit[i] && !busy) ? AVL_BYTE_EN : 4'b0000),
      .wdata   (AVL_WRITEDATA),
      .q       (in_q[i])
    );
    assign CORE_MSG_IN[32*i +: 32] = in_q[i];
  end

  // Result words are loaded only by the core; bus writes never reach them
  for (genvar i = 0; i < MSG_WORDS; i++) begin : g_out
    byte_lane_register u_out (
      .clk     (CLK),
      .rst     (RESET),
      .byte_en (done_evt ? 4'b1111 : 4'b0000),
      .wdata   (CORE_MSG_OUT[32*i +: 32]),
      .q       (out_q[i])
    );
  end

  byte_lane_register u_ien (
    .clk     (CLK),
    .rst     (RESET),
    .byte_en ((wr_en && (AVL_ADDR == ADDR_IEN)) ? AVL_BYTE_EN : 4'b0000),
    .wdata   (AVL_WRITEDATA & IEN_MASK),
    .q       (ien_q)
  );

  // Next-state for the handshake FSM and the sticky status bits
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StBusy;
          start_d = 1'b1;
        end
      end
      StBusy: begin
        if (CORE_DONE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Order matters: clears first, sets last so a coincident set wins
    if (status_w1c && AVL_WRITEDATA[STATUS_DONE_BIT]) done_d = 1'b0;
    if (start_d) done_d = 1'b0;
    if (done_evt) done_d = 1'b1;
    if (status_w1c && AVL_WRITEDATA[STATUS_ERR_BIT]) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // Read-data mux for the addressed register; unmapped and CTRL read 0
  always_comb begin
    rdata_mux = '0;
    for (int unsigned i = 0; i < KEY_WORDS; i++) begin
      if (AVL_ADDR == ADDR_W'(i)) rdata_mux = key_q[i];
    end
    for (int unsigned i = 0; i < MSG_WORDS; i++) begin
      if (AVL_ADDR == ADDR_W'(KEY_WORDS + i)) rdata_mux = in_q[i];
      if (AVL_ADDR == ADDR_W'(OUT_BASE + i)) rdata_mux = out_q[i];
    end
    if (AVL_ADDR == ADDR_STATUS) begin
      rdata_mux[STATUS_BUSY_BIT] = busy;
      rdata_mux[STATUS_DONE_BIT] = done_q;
      rdata_mux[STATUS_ERR_BIT]  = err_q;
    end
    if (AVL_ADDR == ADDR_IEN) rdata_mux = ien_q;
    if (AVL_ADDR == ADDR_ID) rdata_mux = ID_VALUE;
  end

  // State, status, start pulse and registered read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      if (rd_en) readdata_q <= rdata_mux;
    end
  end

  assign AVL_READDATA = readdata_q;
  assign CORE_START   = start_q;
  assign IRQ          = (done_q & ien_q[STATUS_DONE_BIT]) | (err_q & ien_q[STATUS_ERR_BIT]);
  assign EXPORT_DATA  = {out_q[0][31:16], out_q[MSG_WORDS-1][15:0]};

endmodule

// File: tb/tb_avalon_crypto_csr_bank.sv
// Directed self-checking bench for avalon_crypto_csr_bank.
module tb_avalon_crypto_csr_bank;

  localparam int unsigned K  = 4;
  localparam int unsigned M  = 4;
  // One spare address bit so that unmapped addresses exist (the default map is full)
  localparam int unsigned AW = 5;

  localparam logic [AW-1:0] A_KEY0   = 5'd0;
  localparam logic [AW-1:0] A_KEY3   = 5'd3;
  localparam logic [AW-1:0] A_IN0    = 5'd4;
  localparam logic [AW-1:0] A_OUT0   = 5'd8;
  localparam logic [AW-1:0] A_OUT1   = 5'd9;
  localparam logic [AW-1:0] A_CTRL   = 5'd12;
  localparam logic [AW-1:0] A_STATUS = 5'd13;
  localparam logic [AW-1:0] A_IEN    = 5'd14;
  localparam logic [AW-1:0] A_ID     = 5'd15;

  logic            clk;
  logic            reset;
  logic            avl_read;
  logic            avl_write;
  logic            avl_cs;
  logic [3:0]      avl_byte_en;
  logic [AW-1:0]   avl_addr;
  logic [31:0]     avl_writedata;
  logic [31:0]     avl_readdata;
  logic [32*K-1:0] core_key;
  logic [32*M-1:0] core_msg_in;
  logic            core_start;
  logic            core_done;
  logic [32*M-1:0] core_msg_out;
  logic            irq;
  logic [31:0]     export_data;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_crypto_csr_bank #(
    .KEY_WORDS (K),
    .MSG_WORDS (M),
    .ADDR_W    (AW),
    .ID_VALUE  (32'h0000_AE59)
  ) dut (
    .CLK           (clk),
    .RESET         (reset),
    .AVL_READ      (avl_read),
    .AVL_WRITE     (avl_write),
    .AVL_CS        (avl_cs),
    .AVL_BYTE_EN   (avl_byte_en),
    .AVL_ADDR      (avl_addr),
    .AVL_WRITEDATA (avl_writedata),
    .AVL_READDATA  (avl_readdata),
    .CORE_KEY      (core_key),
    .CORE_MSG_IN   (core_msg_in),
    .CORE_START    (core_start),
    .CORE_DONE     (core_done),
    .CORE_MSG_OUT  (core_msg_out),
    .IRQ           (irq),
    .EXPORT_DATA   (export_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic avl_wr(input logic [AW-1:0] addr, input logic [31:0] data,
                        input logic [3:0] be);
    @(negedge clk);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = addr; avl_writedata = data; avl_byte_en = be;
    @(negedge clk);
    avl_cs = 1'b0; avl_write = 1'b0; avl_byte_en = 4'b0000;
  endtask

  task automatic avl_rd(input logic [AW-1:0] addr, output logic [31:0] data);
    @(negedge clk);
    avl_cs = 1'b1; avl_read = 1'b1; avl_addr = addr;
    @(negedge clk);
    avl_cs = 1'b0; avl_read = 1'b0;
    data = avl_readdata;
  endtask

  task automatic pulse_done(input logic [32*M-1:0] msg);
    @(negedge clk);
    core_done = 1'b1; core_msg_out = msg;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [32*M-1:0] msg_a;
    msg_a = {32'hB0B1_B2B3, 32'h0, 32'hC0C1_C2C3, 32'hA0A1_A2A3};

    reset = 1'b1; avl_read = 1'b0; avl_write = 1'b0; avl_cs = 1'b0;
    avl_byte_en = 4'b0000; avl_addr = '0; avl_writedata = '0;
    core_done = 1'b0; core_msg_out = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", avl_readdata, 32'h0);
    check("rst_start", {31'b0, core_start}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_export", export_data, 32'h0);
    check("rst_key0", core_key[31:0], 32'h0);
    reset = 1'b0;

    // ID, STATUS, CTRL and unmapped reads
    avl_rd(A_ID, rd);       check("id", rd, 32'h0000_AE59);
    repeat (2) @(negedge clk);
    check("readdata_hold", avl_readdata, 32'h0000_AE59);
    avl_rd(A_STATUS, rd);   check("status_rst", rd, 32'h0);
    avl_rd(A_CTRL, rd);     check("ctrl_reads0", rd, 32'h0);
    avl_rd(5'd16, rd);      check("unmapped16", rd, 32'h0);
    avl_wr(5'd31, 32'hFFFF_FFFF, 4'hF);
    avl_rd(5'd31, rd);      check("unmapped31", rd, 32'h0);

    // Byte-lane masked writes
    avl_wr(A_KEY0, 32'hFFFF_FFFF, 4'hF);
    avl_wr(A_KEY0, 32'h1234_5678, 4'b0101);
    avl_rd(A_KEY0, rd);     check("key0_be0101", rd, 32'hFF34_FF78);
    check("core_key0", core_key[31:0], 32'hFF34_FF78);
    avl_wr(A_KEY0, 32'h0000_0000, 4'b0000);
    avl_rd(A_KEY0, rd);     check("key0_be0000", rd, 32'hFF34_FF78);
    avl_wr(A_KEY0, 32'hAABB_CCDD, 4'b1010);
    avl_rd(A_KEY0, rd);     check("key0_be1010", rd, 32'hAA34_CC78);
    avl_wr(A_KEY3, 32'h1111_2222, 4'hF);
    check("core_key3", core_key[127:96], 32'h1111_2222);
    avl_wr(A_IN0, 32'h0102_0304, 4'hF);
    check("core_msg_in0", core_msg_in[31:0], 32'h0102_0304);

    // IEN keeps only bits [2:1]
    avl_wr(A_IEN, 32'hFFFF_FFFF, 4'hF);
    avl_rd(A_IEN, rd);      check("ien_mask", rd, 32'h6);
    avl_wr(A_IEN, 32'h0, 4'hF);
    avl_rd(A_IEN, rd);      check("ien_clear", rd, 32'h0);

    // Start an operation: one-cycle pulse, BUSY set
    avl_wr(A_CTRL, 32'h1, 4'hF);
    check("start_pulse", {31'b0, core_start}, 32'h1);
    @(negedge clk);
    check("start_one_cycle", {31'b0, core_start}, 32'h0);
    avl_rd(A_STATUS, rd);   check("status_busy", rd, 32'h1);

    // Protection while busy
    avl_wr(A_IN0, 32'h0000_DEAD, 4'hF);
    avl_wr(A_CTRL, 32'h1, 4'hF);
    check("no_restart", {31'b0, core_start}, 32'h0);
    @(negedge clk);
    check("no_restart2", {31'b0, core_start}, 32'h0);
    avl_rd(A_IN0, rd);      check("in0_protected", rd, 32'h0102_0304);
    avl_rd(A_STATUS, rd);   check("status_err", rd, 32'h5);
    avl_wr(A_STATUS, 32'h4, 4'hF);
    avl_rd(A_STATUS, rd);   check("status_err_w1c", rd, 32'h1);

    // Completion captures the result
    pulse_done(msg_a);
    avl_rd(A_OUT0, rd);     check("out0", rd, 32'hA0A1_A2A3);
    avl_rd(A_OUT1, rd);     check("out1", rd, 32'hC0C1_C2C3);
    avl_rd(A_STATUS, rd);   check("status_done", rd, 32'h2);
    check("export", export_data, 32'hA0A1_B2B3);
    avl_wr(A_OUT0, 32'h0, 4'hF);
    avl_rd(A_OUT0, rd);     check("out0_ro", rd, 32'hA0A1_A2A3);

    // CORE_DONE in IDLE is ignored
    pulse_done({M{32'h5555_5555}});
    avl_rd(A_OUT0, rd);     check("idle_done_ignored", rd, 32'hA0A1_A2A3);

    // Interrupt on DONE
    avl_wr(A_STATUS, 32'h2, 4'hF);
    avl_rd(A_STATUS, rd);   check("done_w1c", rd, 32'h0);
    avl_wr(A_IEN, 32'h2, 4'hF);
    check("irq_idle", {31'b0, irq}, 32'h0);
    avl_wr(A_CTRL, 32'h1, 4'hF);
    check("irq_busy", {31'b0, irq}, 32'h0);
    pulse_done(msg_a);
    check("irq_done", {31'b0, irq}, 32'h1);

    // DONE W1C coincident with CORE_DONE: set wins
    avl_wr(A_CTRL, 32'h1, 4'hF);
    check("irq_cleared_by_start", {31'b0, irq}, 32'h0);
    @(negedge clk);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = A_STATUS; avl_writedata = 32'h2;
    avl_byte_en = 4'hF; core_done = 1'b1; core_msg_out = msg_a;
    @(negedge clk);
    avl_cs = 1'b0; avl_write = 1'b0; avl_byte_en = 4'b0000; core_done = 1'b0;
    check("irq_set_wins", {31'b0, irq}, 32'h1);
    avl_rd(A_STATUS, rd);   check("status_set_wins", rd, 32'h2);

    // Reset mid-operation, then a stray CORE_DONE
    avl_wr(A_CTRL, 32'h1, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulse_done({M{32'h7777_7777}});
    avl_rd(A_OUT0, rd);     check("rst_out0", rd, 32'h0);
    avl_rd(A_STATUS, rd);   check("rst_status", rd, 32'h0);
    check("rst_irq2", {31'b0, irq}, 32'h0);
    check("rst_export2", export_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
